// File: rtl/btn_pkg.sv
// Shared types, default timing constants and width helper for the button conditioner.
// Auto-repeat types are only consumed when AUTOREPEAT_EN is defined.
package btn_pkg;

    typedef enum logic [1:0] {
        REL = 2'd0,
        DLY = 2'd1,
        RPT = 2'd2
    } rpt_state_e;

    localparam int DEF_N            = 7;
    localparam int DEF_STABLE_TICKS = 8;
    localparam int DEF_CNT_W        = 4;
    localparam int DEF_REPEAT_DELAY = 32;
    localparam int DEF_REPEAT_RATE  = 8;

    // Smallest width w with 2**w >= value.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: 2-flop synchroniser, tick-based debounce, press/release pulses.
// Defining AUTOREPEAT_EN adds a REL/DLY/RPT auto-repeat FSM driving repeat_o.
module button_channel
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic pb_i,
    output logic state_o,
    output logic down_o,
    output logic up_o,
    output logic repeat_o
);

    if (STABLE_TICKS < 2 || (1 << CNT_W) <= STABLE_TICKS ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("button_channel: invalid timing parameters");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [1:0]       sync_q;
    logic             pressed;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             down_q, down_d;
    logic             up_q, up_d;

    // Contacts idle high, so the synchroniser resets to "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pb_i};
        end
    end

    assign pressed = ~sync_q[1];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        down_d  = 1'b0;
        up_d    = 1'b0;
        if (tick_i) begin
            if (pressed == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = pressed;
                cnt_d   = '0;
                down_d  = pressed;
                up_d    = ~pressed;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 1'b0;
            cnt_q   <= '0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            up_q    <= up_d;
        end
    end

    assign state_o = state_q;
    assign down_o  = down_q;
    assign up_o    = up_q;

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = clog2(RPT_MAX + 1);

    rpt_state_e       rs_q, rs_d;
    logic [RPT_W-1:0] rc_q, rc_d;
    logic             repeat_q, repeat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q     <= REL;
            rc_q     <= '0;
            repeat_q <= 1'b0;
        end else begin
            rs_q     <= rs_d;
            rc_q     <= rc_d;
            repeat_q <= repeat_d;
        end
    end

    // A release seen on the same tick as a repeat deadline wins: no pulse after UP.
    always_comb begin
        rs_d     = rs_q;
        rc_d     = rc_q;
        repeat_d = 1'b0;
        case (rs_q)
            REL: begin
                if (down_d) begin
                    rs_d = DLY;
                    rc_d = '0;
                end
            end
            DLY, RPT: begin
                if (up_d) begin
                    rs_d = REL;
                    rc_d = '0;
                end else if (tick_i) begin
                    if (rc_q == ((rs_q == DLY) ? RPT_W'(REPEAT_DELAY - 1)
                                               : RPT_W'(REPEAT_RATE - 1))) begin
                        rs_d     = RPT;
                        rc_d     = '0;
                        repeat_d = 1'b1;
                    end else begin
                        rc_d = rc_q + RPT_W'(1);
                    end
                end
            end
            default: begin
                rs_d = REL;
                rc_d = '0;
            end
        endcase
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton front end: N independent button_channel instances.
// Auto-repeat is built in only when AUTOREPEAT_EN is defined.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_i,
    input  logic [N-1:0] pb_i,
    output logic [N-1:0] state_o,
    output logic [N-1:0] down_o,
    output logic [N-1:0] up_o,
    output logic [N-1:0] repeat_o
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        button_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (tick_i),
            .pb_i     (pb_i[i]),
            .state_o  (state_o[i]),
            .down_o   (down_o[i]),
            .up_o     (up_o[i]),
            .repeat_o (repeat_o[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (N=2, STABLE_TICKS=4, TICK every 4 CLK).
// Expected repeat pulses are added when AUTOREPEAT_EN is defined.
module tb_button_conditioner;

    localparam int N = 2;

    typedef struct {
        int         tick;
        logic [1:0] down;
        logic [1:0] up;
        logic [1:0] rpt;
        logic [1:0] state;
    } ev_t;

    logic         clk;
    logic         rst_n;
    logic         tick;
    logic         tick_en;
    logic [N-1:0] pb;
    logic [N-1:0] state_o, down_o, up_o, repeat_o;

    ev_t  exp_q[$];
    ev_t  ev;
    int   tick_cnt;
    int   n_checks;
    int   n_pass;
    int   div;
    logic ticked;

    button_conditioner #(
        .N            (N),
        .STABLE_TICKS (4),
        .CNT_W        (3),
        .REPEAT_DELAY (6),
        .REPEAT_RATE  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_i   (tick),
        .pb_i     (pb),
        .state_o  (state_o),
        .down_o   (down_o),
        .up_o     (up_o),
        .repeat_o (repeat_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-CLK tick every fourth cycle while enabled.
    initial begin
        tick = 1'b0;
        div  = 0;
        forever begin
            @(negedge clk);
            tick = tick_en && (div == 0);
            div  = (div + 1) % 4;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_ev(input int at, input logic [1:0] d, input logic [1:0] u,
                             input logic [1:0] r, input logic [1:0] s);
        ev_t e;
        e.tick  = at;
        e.down  = d;
        e.up    = u;
        e.rpt   = r;
        e.state = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = tick_cnt + n;
        budget = n * 8 + 16;
        while (tick_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (tick_cnt < target) check("tick_timeout", 32'(tick_cnt), 32'(target));
    endtask

    task automatic press_release(input logic [1:0] m, input int hold);
        pb = pb & ~m;
        expect_ev(tick_cnt + 4, m, 2'b00, 2'b00, m);
        wait_ticks(hold);
        pb = pb | m;
        expect_ev(tick_cnt + 4, 2'b00, m, 2'b00, 2'b00);
        wait_ticks(6);
    endtask

    // Monitor: every pulse must match the head of the scoreboard, tick-exact.
    initial begin
        tick_cnt = 0;
        forever begin
            @(posedge clk);
            ticked = tick;
            #1;
            if (ticked) tick_cnt++;
            if ((down_o | up_o | repeat_o) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({down_o, up_o, repeat_o}), 32'(0));
                end else begin
                    ev = exp_q.pop_front();
                    check("ev_tick", 32'(tick_cnt), 32'(ev.tick));
                    check("ev_pulses", 32'({down_o, up_o, repeat_o}),
                          32'({ev.down, ev.up, ev.rpt}));
                    check("ev_state", 32'(state_o), 32'(ev.state));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        tick_en  = 1'b1;
        pb       = 2'b00;

        // Reset with both buttons held down.
        repeat (3) @(negedge clk);
        check("rst_state",  32'(state_o),  32'(0));
        check("rst_down",   32'(down_o),   32'(0));
        check("rst_up",     32'(up_o),     32'(0));
        check("rst_repeat", 32'(repeat_o), 32'(0));
        wait_ticks(1);
        rst_n = 1'b1;
        expect_ev(tick_cnt + 4, 2'b11, 2'b00, 2'b00, 2'b11);
        wait_ticks(5);
        check("q_after_reset", 32'(exp_q.size()), 32'(0));
        pb = 2'b11;
        expect_ev(tick_cnt + 4, 2'b00, 2'b11, 2'b00, 2'b00);
        wait_ticks(6);
        check("q_both_release", 32'(exp_q.size()), 32'(0));

        // Clean press/release on each channel.
        press_release(2'b01, 5);
        check("q_clean_ch0", 32'(exp_q.size()), 32'(0));
        press_release(2'b10, 5);
        check("q_clean_ch1", 32'(exp_q.size()), 32'(0));

        // Bounce: three differing ticks then back to released.
        pb = 2'b10;
        wait_ticks(3);
        pb = 2'b11;
        wait_ticks(6);
        check("bounce_state", 32'(state_o), 32'(0));
        // A following press needs the full four ticks again.
        press_release(2'b01, 5);
        check("q_after_bounce", 32'(exp_q.size()), 32'(0));

        // TICK paused for 100 CLK while channel 1 is held.
        pb = 2'b01;
        t0 = tick_cnt;
        expect_ev(t0 + 4, 2'b10, 2'b00, 2'b00, 2'b10);
        wait_ticks(2);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        check("pause_state", 32'(state_o), 32'(0));
        check("pause_queue", 32'(exp_q.size()), 32'(1));
        tick_en = 1'b1;
        wait_ticks(3);
        pb = 2'b11;
        expect_ev(tick_cnt + 4, 2'b00, 2'b10, 2'b00, 2'b00);
        wait_ticks(6);
        check("q_after_pause", 32'(exp_q.size()), 32'(0));

        // Long hold on channel 0: repeats only when auto-repeat is built in.
        pb = 2'b10;
        t0 = tick_cnt;
        expect_ev(t0 + 4, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) expect_ev(t0 + 10 + 2 * k, 2'b00, 2'b00, 2'b01, 2'b01);
`endif
        wait_ticks(15);
        pb = 2'b11;
        expect_ev(tick_cnt + 4, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_ticks(8);
        check("q_after_hold", 32'(exp_q.size()), 32'(0));

        // Reset asserted mid-hold: outputs clear at once, no UP, DOWN re-issued.
        pb = 2'b10;
        expect_ev(tick_cnt + 4, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_ticks(5);
        check("hold_state", 32'(state_o), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state_o), 32'(0));
        check("async_rst_pulses", 32'({down_o, up_o, repeat_o}), 32'(0));
        wait_ticks(1);
        rst_n = 1'b1;
        expect_ev(tick_cnt + 4, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_ticks(5);
        pb = 2'b11;
        expect_ev(tick_cnt + 4, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_ticks(6);
        check("q_final", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
